// File: rtl/vga_pkg.sv
// Shared constants, types and address helper for the VGA text-cell renderer.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COLS     = 80;
    localparam int ROWS     = 60;
    localparam int CELL     = 8;
    localparam int LAT      = 5;

    localparam int TILE_AW  = 13;
    localparam int FONT_AW  = 11;

    typedef logic [7:0] rgb332_t;

    // Per-pixel side information that travels alongside the memory lookups.
    typedef struct packed {
        logic       active;
        logic       inv;
        logic [2:0] x_lo;
        logic [2:0] y_lo;
    } pix_meta_t;

    // row*80 + col as (row<<6)+(row<<4)+col; 13 bits hold 59*80+79 = 4799.
    function automatic logic [TILE_AW-1:0] tile_index(input logic [6:0] row,
                                                      input logic [6:0] col);
        logic [TILE_AW-1:0] r;
        r = {6'd0, row};
        return (r << 6) + (r << 4) + {6'd0, col};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Async-reset shift register: dout is din delayed by DEPTH clocks.
module vga_delay_line #(
    parameter int               DEPTH   = 4,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Each stage takes the previous one; stage 0 takes the input.
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset clears every stage to RST_VAL so no stale data survives reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_tile_renderer.sv
// Text-mode pixel stage: 80x60 cells of 8x8 glyphs, blinking block cursor,
// RGB332 output with syncs delayed to the same five-clock pipeline depth.
// Timeline per pixel: edge1 tile_addr, edge2 tile RAM read, edge3 font_addr,
// edge4 font ROM read, edge5 rgb. The pipeline advances every clock.
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter rgb332_t FG_RGB       = 8'hFF,
    parameter rgb332_t BG_RGB       = 8'h00,
    parameter int      BLINK_FRAMES = 30,
    parameter logic    SYNC_IDLE    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         x_axis,
    input  logic [9:0]         y_axis,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    output logic [TILE_AW-1:0] tile_addr,
    input  logic [7:0]         tile_data,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [7:0]         font_data,
    input  logic               cursor_en,
    input  logic [6:0]         cursor_col,
    input  logic [5:0]         cursor_row,
    output rgb332_t            rgb,
    output logic               h_sync,
    output logic               v_sync,
    output logic               frame_tick
);

    localparam int               CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [6:0]         col, row;
    logic               active, cursor_hit, at_origin, pix_bit;
    pix_meta_t          meta_in, meta_mid;
    logic [4:0]         late_in, late_out;   // {active, inv, x_lo}
    logic [1:0]         sync_out;

    logic [TILE_AW-1:0] tile_addr_d, tile_addr_q;
    logic [FONT_AW-1:0] font_addr_d, font_addr_q;
    rgb332_t            rgb_d, rgb_q;
    logic               frame_tick_d, frame_tick_q;
    logic               origin_d, origin_q;
    logic [CNT_W-1:0]   blink_cnt_d, blink_cnt_q;
    logic               blink_phase_d, blink_phase_q;

    // Syncs ride a plain 5-deep line so they stay aligned with rgb.
    vga_delay_line #(.DEPTH(5), .WIDTH(2), .RST_VAL({SYNC_IDLE, SYNC_IDLE})) u_sync_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({h_sync_in, v_sync_in}),
        .dout (sync_out)
    );

    // Pixel metadata, first two stages: y_lo is consumed at edge3 for font_addr.
    vga_delay_line #(.DEPTH(2), .WIDTH(8), .RST_VAL(8'd0)) u_meta_early (
        .clk  (clk),
        .rst  (rst),
        .din  (meta_in),
        .dout (meta_mid)
    );

    // Remaining two stages carry only what the output mux needs at edge5.
    vga_delay_line #(.DEPTH(2), .WIDTH(5), .RST_VAL(5'd0)) u_meta_late (
        .clk  (clk),
        .rst  (rst),
        .din  (late_in),
        .dout (late_out)
    );

    // Address arithmetic, cursor hit, frame-start detect, blink counter, output mux.
    always_comb begin
        col        = x_axis[9:3];
        row        = y_axis[9:3];
        active     = (x_axis < 10'(H_ACTIVE)) && (y_axis < 10'(V_ACTIVE));
        // Gating with active keeps out-of-range cursor values from ever hitting.
        cursor_hit = cursor_en && active && (col == cursor_col) && (row == {1'b0, cursor_row});
        at_origin  = (x_axis == 10'd0) && (y_axis == 10'd0);

        meta_in.active = active;
        meta_in.inv    = cursor_hit && blink_phase_q;
        meta_in.x_lo   = x_axis[2:0];
        meta_in.y_lo   = y_axis[2:0];
        late_in        = {meta_mid.active, meta_mid.inv, meta_mid.x_lo};

        tile_addr_d  = active ? tile_index(row, col) : '0;
        font_addr_d  = {tile_data, meta_mid.y_lo};

        frame_tick_d = at_origin && !origin_q;
        origin_d     = at_origin;

        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_tick_q) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // bit7 of the glyph row is the leftmost pixel, so index with 7-x.
        pix_bit = font_data[~late_out[2:0]];
        if (!late_out[4]) begin
            rgb_d = '0;
        end else if (pix_bit ^ late_out[3]) begin
            rgb_d = FG_RGB;
        end else begin
            rgb_d = BG_RGB;
        end
    end

    // All top-level state; async reset returns everything to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_addr_q   <= '0;
            font_addr_q   <= '0;
            rgb_q         <= '0;
            frame_tick_q  <= 1'b0;
            origin_q      <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            tile_addr_q   <= tile_addr_d;
            font_addr_q   <= font_addr_d;
            rgb_q         <= rgb_d;
            frame_tick_q  <= frame_tick_d;
            origin_q      <= origin_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign tile_addr  = tile_addr_q;
    assign font_addr  = font_addr_q;
    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;
    assign h_sync     = sync_out[1];
    assign v_sync     = sync_out[0];

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer with tile RAM / font ROM models.
module tb_vga_tile_renderer;

    localparam int BLINK = 2;
    localparam int MF_W  = 32;
    localparam int MF_H  = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  x_axis = '0, y_axis = '0;
    logic        h_sync_in = 1'b1, v_sync_in = 1'b1;
    logic [12:0] tile_addr;
    logic [7:0]  tile_data = '0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = '0;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [5:0]  cursor_row = '0;
    logic [7:0]  rgb;
    logic        h_sync, v_sync, frame_tick;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_ticks = 0;
    logic        model_prev_zero = 1'b0;
    logic [9:0]  exp_q[$];   // {rgb, h_sync, v_sync} per driven pixel

    // clock / reset block
    always #5 clk = ~clk;

    vga_tile_renderer #(
        .FG_RGB(8'hFF), .BG_RGB(8'h00), .BLINK_FRAMES(BLINK), .SYNC_IDLE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .x_axis(x_axis), .y_axis(y_axis),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .tile_addr(tile_addr), .tile_data(tile_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .rgb(rgb), .h_sync(h_sync), .v_sync(v_sync), .frame_tick(frame_tick)
    );

    function automatic logic [7:0] tile_fn(input logic [12:0] a);
        int v;
        if (a == 13'd161) return 8'h41;
        v = int'(a) * 13 + 5;
        return v[7:0];
    endfunction

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        int v;
        if (a == 11'h208) return 8'h80;
        v = (int'(a) * 37) ^ (int'(a) >> 3);
        return v[7:0];
    endfunction

    // synchronous-read memories
    always @(posedge clk) begin
        tile_data <= tile_fn(tile_addr);
        font_data <= font_fn(font_addr);
    end

    function automatic logic [7:0] exp_pix(input logic [9:0] x, input logic [9:0] y, input logic ph);
        int col, row;
        logic [7:0] ch, g;
        logic b, inv;
        if (x >= 10'd640 || y >= 10'd480) return 8'h00;
        col = int'(x) / 8;
        row = int'(y) / 8;
        ch  = tile_fn(13'(row * 80 + col));
        g   = font_fn({ch, y[2:0]});
        b   = g[7 - int'(x[2:0])];
        inv = cursor_en && (col == int'(cursor_col)) && (row == int'(cursor_row)) && ph;
        return (b ^ inv) ? 8'hFF : 8'h00;
    endfunction

    // driver: apply one pixel, record its expected output, advance one clock
    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic hs, input logic vs);
        logic ph;
        x_axis = x; y_axis = y; h_sync_in = hs; v_sync_in = vs;
        if (x == 10'd0 && y == 10'd0 && !model_prev_zero) model_ticks++;
        model_prev_zero = (x == 10'd0 && y == 10'd0);
        ph = ((model_ticks / BLINK) % 2) == 1;
        exp_q.push_back({exp_pix(x, y, ph), hs, vs});
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_ticks = 0;
        model_prev_zero = 1'b0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        cursor_en = 1'b0;
        x_axis = 10'd100; y_axis = 10'd100; h_sync_in = 1'b1; v_sync_in = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rgb !== 8'h00) begin n_fail++; $display("FAIL reset_rgb got=%h exp=00", rgb); end
        n_checks++;
        if ({h_sync, v_sync} !== 2'b11) begin n_fail++; $display("FAIL reset_sync got=%b exp=11", {h_sync, v_sync}); end
        n_checks++;
        if (tile_addr !== 13'd0) begin n_fail++; $display("FAIL reset_tile_addr got=%0d exp=0", tile_addr); end
        n_checks++;
        if ({font_addr, frame_tick} !== 12'd0) begin
            n_fail++; $display("FAIL reset_font_tick got=%h/%b exp=0/0", font_addr, frame_tick);
        end
        rst = 1'b1;
        model_reset();
        for (int e = 1; e <= 5; e++) begin
            drive(10'd8, 10'd16, 1'b0, 1'b0);
            n_checks++;
            if (rgb !== ((e == 5) ? 8'hFF : 8'h00) || {h_sync, v_sync} !== ((e == 5) ? 2'b00 : 2'b11)) begin
                n_fail++;
                $display("FAIL release_edge%0d got rgb=%h sync=%b", e, rgb, {h_sync, v_sync});
            end
        end
    endtask

    task automatic test_tile_font();
        logic [7:0] e;
        exp_q.delete();
        drive(10'd100, 10'd100, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            drive(10'(8 + i), 10'd16, 1'b1, 1'b1);
            if (i == 0) begin
                n_checks++;
                if (tile_addr !== 13'd161) begin n_fail++; $display("FAIL tile_addr_8_16 got=%0d exp=161", tile_addr); end
            end
            if (i == 2) begin
                n_checks++;
                if (font_addr !== 11'h208) begin n_fail++; $display("FAIL font_addr got=%h exp=208", font_addr); end
            end
            if (i >= 4) begin
                e = (i == 4) ? 8'hFF : 8'h00;
                n_checks++;
                if (rgb !== e) begin n_fail++; $display("FAIL glyph_x%0d got=%h exp=%h", 4 + i, rgb, e); end
            end
        end
    endtask

    task automatic test_boundary();
        logic [9:0]  ax [4] = '{10'd639, 10'd640, 10'd639, 10'd1023};
        logic [9:0]  ay [4] = '{10'd479, 10'd479, 10'd480, 10'd1023};
        logic [12:0] ea [4] = '{13'd4799, 13'd0, 13'd0, 13'd0};
        int          rows [6] = '{0, 7, 472, 479, 480, 529};
        logic [12:0] max_addr;
        logic [9:0]  e, bad_got, bad_exp;
        int          bad;
        exp_q.delete();
        max_addr = '0; bad = 0; bad_got = '0; bad_exp = '0;
        for (int i = 0; i < 4; i++) begin
            drive(ax[i], ay[i], 1'b1, 1'b1);
            n_checks++;
            if (tile_addr !== ea[i]) begin
                n_fail++; $display("FAIL edge_addr_%0d_%0d got=%0d exp=%0d", ax[i], ay[i], tile_addr, ea[i]);
            end
            if (exp_q.size() == 5) begin
                e = exp_q.pop_front();
                if ({rgb, h_sync, v_sync} !== e) begin
                    if (bad == 0) begin bad_got = {rgb, h_sync, v_sync}; bad_exp = e; end
                    bad++;
                end
            end
        end
        for (int r = 0; r < 6; r++) begin
            for (int x = 0; x < 802; x++) begin
                drive(10'(x), 10'(rows[r]), 1'b1, 1'b1);
                if (tile_addr > max_addr) max_addr = tile_addr;
                if (exp_q.size() == 5) begin
                    e = exp_q.pop_front();
                    if ({rgb, h_sync, v_sync} !== e) begin
                        if (bad == 0) begin bad_got = {rgb, h_sync, v_sync}; bad_exp = e; end
                        bad++;
                    end
                end
            end
        end
        n_checks++;
        if (max_addr !== 13'd4799) begin n_fail++; $display("FAIL max_tile_addr got=%0d exp=4799", max_addr); end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL boundary_pixels bad=%0d first got=%h exp=%h", bad, bad_got, bad_exp);
        end
    endtask

    task automatic test_sync();
        logic [15:0] obs_h, obs_v;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            drive(10'd200, 10'd100, !(i >= 2 && i < 5), !(i >= 3 && i < 5));
            obs_h[i] = h_sync;
            obs_v[i] = v_sync;
        end
        n_checks++;
        if (obs_h !== 16'hFE3F) begin n_fail++; $display("FAIL h_sync_delay got=%h exp=FE3F", obs_h); end
        n_checks++;
        if (obs_v !== 16'hFE7F) begin n_fail++; $display("FAIL v_sync_delay got=%h exp=FE7F", obs_v); end
    endtask

    task automatic test_cursor();
        logic [9:0] e, bad_got, bad_exp;
        logic [7:0] ec;
        int         bad, ticks;
        apply_reset();
        cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 6'd2;
        bad = 0; ticks = 0; bad_got = '0; bad_exp = '0;
        for (int f = 1; f <= 8; f++) begin
            for (int y = 0; y < MF_H; y++) begin
                for (int x = 0; x < MF_W; x++) begin
                    drive(10'(x), 10'(y), 1'b1, 1'b1);
                    if (frame_tick) ticks++;
                    if (exp_q.size() == 5) begin
                        e = exp_q.pop_front();
                        if ({rgb, h_sync, v_sync} !== e) begin
                            if (bad == 0) begin bad_got = {rgb, h_sync, v_sync}; bad_exp = e; end
                            bad++;
                        end
                    end
                    // output now belongs to pixel (24,16), left edge of the cursor cell
                    if (x == 28 && y == 16) begin
                        ec = ((f % 4) == 2 || (f % 4) == 3) ? 8'h00 : 8'hFF;
                        n_checks++;
                        if (rgb !== ec) begin n_fail++; $display("FAIL cursor_frame%0d got=%h exp=%h", f, rgb, ec); end
                    end
                end
            end
        end
        n_checks++;
        if (ticks != 8) begin n_fail++; $display("FAIL frame_tick_count got=%0d exp=8", ticks); end
        ticks = 0;
        for (int i = 0; i < 3; i++) begin
            drive(10'd0, 10'd0, 1'b1, 1'b1);
            if (frame_tick) ticks++;
        end
        n_checks++;
        if (ticks != 1) begin n_fail++; $display("FAIL frame_tick_hold got=%0d exp=1", ticks); end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL cursor_pixels bad=%0d first got=%h exp=%h", bad, bad_got, bad_exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] e, bad_got, bad_exp;
        logic [7:0] ec;
        int         bad, ticks, early_bad;
        bad = 0; ticks = 0; early_bad = 0; bad_got = '0; bad_exp = '0;
        exp_q.delete();
        // one more frame puts the blink phase at 1 before the reset
        for (int y = 0; y < MF_H; y++)
            for (int x = 0; x < MF_W; x++)
                drive(10'(x), 10'(y), 1'b1, 1'b1);
        for (int x = 296; x <= 300; x++) drive(10'(x), 10'd200, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rgb, h_sync, v_sync, frame_tick} !== {8'h00, 2'b11, 1'b0} || tile_addr !== 13'd0 || font_addr !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset got rgb=%h sync=%b tick=%b ta=%0d fa=%0d", rgb, {h_sync, v_sync}, frame_tick, tile_addr, font_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int x = 301; x <= 320; x++) begin
            drive(10'(x), 10'd200, 1'b1, 1'b1);
            if (frame_tick) ticks++;
            if (x < 305 && {rgb, h_sync, v_sync} !== {8'h00, 2'b11}) early_bad++;
            if (exp_q.size() == 5) begin
                e = exp_q.pop_front();
                if ({rgb, h_sync, v_sync} !== e) begin
                    if (bad == 0) begin bad_got = {rgb, h_sync, v_sync}; bad_exp = e; end
                    bad++;
                end
            end
        end
        n_checks++;
        if (ticks != 0) begin n_fail++; $display("FAIL spurious_tick got=%0d exp=0", ticks); end
        n_checks++;
        if (early_bad != 0) begin n_fail++; $display("FAIL post_reset_idle bad=%0d exp=0", early_bad); end
        for (int f = 1; f <= 2; f++) begin
            for (int y = 0; y < MF_H; y++) begin
                for (int x = 0; x < MF_W; x++) begin
                    drive(10'(x), 10'(y), 1'b1, 1'b1);
                    if (exp_q.size() == 5) begin
                        e = exp_q.pop_front();
                        if ({rgb, h_sync, v_sync} !== e) begin
                            if (bad == 0) begin bad_got = {rgb, h_sync, v_sync}; bad_exp = e; end
                            bad++;
                        end
                    end
                    if (x == 28 && y == 16) begin
                        ec = (f == 2) ? 8'h00 : 8'hFF;
                        n_checks++;
                        if (rgb !== ec) begin n_fail++; $display("FAIL restart_frame%0d got=%h exp=%h", f, rgb, ec); end
                    end
                end
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL restart_pixels bad=%0d first got=%h exp=%h", bad, bad_got, bad_exp);
        end
    endtask

    initial begin
        test_reset();
        test_tile_font();
        test_boundary();
        test_sync();
        test_cursor();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
